// File: rtl/prirv32_bus_pkg.sv
// Shared priRV32 data-bus definitions: register offsets, responder FSM states
// and the request bundle.
package prirv32_bus_pkg;

  localparam logic [3:0] LED_OUT_OFS      = 4'h0;
  localparam logic [3:0] BLINK_CTRL_OFS   = 4'h4;
  localparam logic [3:0] BLINK_PERIOD_OFS = 4'h8;
  localparam logic [3:0] COUNTER_OFS      = 4'hC;

  typedef enum logic {
    StIdle,
    StResp
  } bus_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  // Word index of a byte offset within the 16-byte register window.
  function automatic logic [1:0] reg_idx(input logic [3:0] ofs);
    return ofs[3:2];
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running blink counter; pulses toggle_o once every period_i cycles while enabled.
module blink_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] period_i,
  output logic [CNT_W-1:0] count_o,
  output logic             toggle_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             run, wrap;

  always_comb begin
    run     = en_i && (period_i != '0);
    wrap    = run && (count_q == period_i - CNT_W'(1));
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A clearing write restarts the period, so the pending toggle is dropped.
  assign toggle_o = wrap && !clear_i;
  assign count_o  = count_q;

endmodule

// File: rtl/led_gpio_responder.sv
// LED/GPIO responder on the priRV32 data bus: LED output register plus hardware blink timer,
// one outstanding request with a registered response.
module led_gpio_responder
  import prirv32_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned CNT_W      = 32,
  parameter logic [31:0] RST_PERIOD = 32'd25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              led
);

  localparam logic [1:0] IdxLed    = reg_idx(LED_OUT_OFS);
  localparam logic [1:0] IdxCtrl   = reg_idx(BLINK_CTRL_OFS);
  localparam logic [1:0] IdxPeriod = reg_idx(BLINK_PERIOD_OFS);
  localparam logic [1:0] IdxCount  = reg_idx(COUNTER_OFS);

  bus_state_e       state_q;
  bus_req_t         req;
  logic             led_out_q, blink_en_q;
  logic [CNT_W-1:0] period_q, period_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             accept, addr_hi_err, wr;
  logic [1:0]       idx;
  logic             wr_led, wr_ctrl, wr_period, en_rise, timer_clear, toggle;
  logic [CNT_W-1:0] count;
  logic [31:0]      period_old, period_mrg;
  logic             unused_addr;

  always_comb begin
    req                    = '0;
    req.we                 = req_we;
    req.addr[ADDR_W-1:0]   = req_addr;
    req.wdata              = req_wdata;
    req.wstrb              = req_wstrb;
  end

  assign unused_addr = ^req.addr[1:0];

  assign accept      = (state_q == StIdle) && req_valid;
  assign addr_hi_err = |req.addr[31:4];
  assign idx         = req.addr[3:2];
  assign wr          = accept && req.we && !addr_hi_err;

  assign wr_led      = wr && (idx == IdxLed) && req.wstrb[0];
  assign wr_ctrl     = wr && (idx == IdxCtrl) && req.wstrb[0];
  assign wr_period   = wr && (idx == IdxPeriod) && (|req.wstrb);
  assign en_rise     = wr_ctrl && req.wdata[0] && !blink_en_q;
  assign timer_clear = en_rise || wr_period;

  // Byte-lane merge of the write data into the zero-extended period.
  always_comb begin
    period_old = 32'(period_q);
    period_mrg = period_old;
    for (int i = 0; i < 4; i++) begin
      if (req.wstrb[i]) begin
        period_mrg[8*i +: 8] = req.wdata[8*i +: 8];
      end
    end
    period_d = period_mrg[CNT_W-1:0];
  end

  always_comb begin
    err_d   = addr_hi_err || (req.we && (idx == IdxCount));
    rdata_d = '0;
    if (!req.we && !addr_hi_err) begin
      case (idx)
        IdxLed:    rdata_d = {31'b0, led_out_q};
        IdxCtrl:   rdata_d = {31'b0, blink_en_q};
        IdxPeriod: rdata_d = 32'(period_q);
        default:   rdata_d = 32'(count);
      endcase
    end
  end

  blink_timer #(
    .CNT_W(CNT_W)
  ) u_blink_timer (
    .clk      (clk),
    .rst      (rst),
    .en_i     (blink_en_q),
    .clear_i  (timer_clear),
    .period_i (period_q),
    .count_o  (count),
    .toggle_o (toggle)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      led_out_q  <= 1'b0;
      blink_en_q <= 1'b0;
      period_q   <= CNT_W'(RST_PERIOD);
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
            state_q <= StResp;
          end
        end
        default: begin
          if (resp_ready) begin
            state_q <= StIdle;
          end
        end
      endcase

      // Software write to LED_OUT overrides a coincident timer toggle.
      if (wr_led) begin
        led_out_q <= req.wdata[0];
      end else if (toggle) begin
        led_out_q <= ~led_out_q;
      end
      if (wr_ctrl) begin
        blink_en_q <= req.wdata[0];
      end
      if (wr_period) begin
        period_q <= period_d;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign led        = led_out_q;

endmodule

// File: doc/led_gpio_responder.md
Name: led_gpio_responder

Overview:
- Memory-mapped LED/GPIO peripheral on the priRV32 data bus.
- Core is initiator; this block is the responder that drives the board `led` pin.
- Holds an LED output register and a hardware blink timer.
- One outstanding request, registered response, backpressure on both request and response channels.

Parameters:
- ADDR_W, 4, request byte-address width (register window 16 B).
- CNT_W, 32, blink counter/period width (≤ 32).
- RST_PERIOD, 32'd25_000_000, reset value of BLINK_PERIOD.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core presents request
- req_ready  out  1  block accepts request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address; [1:0] ignored
- req_wdata  in  32  write data
- req_wstrb  in  4  byte-lane enables for writes
- resp_valid  out  1  response available
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  read data (0 for writes/errors)
- resp_err  out  1  unmapped address
- led  out  1  LED pin, = LED_OUT bit0

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on posedge clk; `rst` sampled only at the edge.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, led=0, LED_OUT=0, BLINK_EN=0, BLINK_PERIOD=RST_PERIOD, COUNTER=0, FSM=IDLE.
- Register map (word index = req_addr[3:2]):
  - 0 LED_OUT: RW, bit0 only, upper bits read 0.
  - 1 BLINK_CTRL: RW, bit0 = BLINK_EN.
  - 2 BLINK_PERIOD: RW, CNT_W bits, zero-extended on read.
  - 3 COUNTER: RO; a write returns resp_err=1 with no side effect.
  - With ADDR_W>4, any nonzero req_addr[ADDR_W-1:4] → resp_err=1, rdata=0, no side effect.
- FSM:
  - IDLE: req_ready=1. On req_valid (handshake), perform the access this edge, latch rdata/err, go to RESP.
  - RESP: req_ready=0, resp_valid=1, resp_rdata/resp_err stable. On resp_ready, go to IDLE. No combinational path req_valid→req_ready.
  - Latency: response visible the cycle after request acceptance. Minimum 2 cycles per transaction.
- Writes: byte lanes honoured via req_wstrb; wstrb=0 is a legal no-op returning resp_err=0.
- Blink timer:
  - Runs when BLINK_EN=1 and BLINK_PERIOD≠0.
  - Each cycle COUNTER+1; at COUNTER==BLINK_PERIOD-1, COUNTER←0 and LED_OUT[0] toggles. Toggle period = BLINK_PERIOD cycles.
  - BLINK_PERIOD=0 or BLINK_EN=0: COUNTER holds, no toggles.
  - Writing BLINK_PERIOD or setting BLINK_EN 0→1 clears COUNTER the same edge.
  - Lowering BLINK_PERIOD below the current COUNTER is impossible, because the write clears COUNTER.
- Simultaneous events: a software write to LED_OUT on the same edge as a timer toggle — software value wins, timer toggle dropped. The read data of COUNTER is the pre-edge value.
- Reset mid-transaction: pending response discarded, resp_valid=0 next cycle, all registers to reset values.

Decomposition:
- Shared package `prirv32_bus_pkg`: register offset constants (LED_OUT_OFS=0, BLINK_CTRL_OFS=4, BLINK_PERIOD_OFS=8, COUNTER_OFS=12), FSM state enum {IDLE, RESP}, and a bus request struct (we, addr, wdata, wstrb).
- One sub-module `blink_timer`: counter, period compare and toggle pulse output. LED_OUT ownership stays in the parent.

Test Plan:
- Reset: assert rst 2 cycles → led=0, req_ready=1, resp_valid=0; read offset 8 → rdata=RST_PERIOD, err=0.
- Write 0x1 to offset 0 (wstrb=4'hF) → resp_valid exactly 1 cycle after accept, err=0; led=1 next cycle; readback=0x1.
- BLINK_PERIOD=4, BLINK_EN=1, resp_ready tied 1 → led toggles every 4 clk; COUNTER reads in range 0..3 only.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid stays 1, rdata stable, req_ready=0; new req_valid not accepted until resp_ready=1.
- Errors: write to offset 12 and to 0x10 (ADDR_W=5) → resp_err=1, rdata=0, registers unchanged; wstrb=4'b0010 write to offset 8 → only bits[15:8] change.
- Collision and reset: write LED_OUT=0 on the same edge as a scheduled toggle → led=0. Assert rst while in RESP → resp_valid=0 and BLINK_EN=0 next cycle.
